avalon_mat_mult_csr: RTL and testbench
======================================

// Module: avalon_mat_mult_csr
// PURPOSE
//  Avalon-MM slave front-end for the complex matrix multiplier mat_mult_complex. It holds the A, B and C banks
//  as one 64-bit word per complex element, {imag[63:32], real[31:0]}. A CSR pair replaces stall-the-bus
//  waitrequest, so software polls STATUS or waits for irq. Adds per-byte enables, a timeout and sticky flags.
//  Sits between the HPS/Avalon interconnect and the mat_mult_complex core.
// PARAMETERS
//  MAT_N        3      matrix dimension; A, B and C are each MAT_N x MAT_N
//  ADDR_W       23     Avalon word-address width; must hold 3*MAT_N*MAT_N+2 addresses
//  TIMEOUT_CYC  4096   max cycles in RUN before the error flag is set; 0 disables the timeout
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  reset_n        in   1       synchronous, active-low reset
//  address        in   ADDR_W  64-bit word address
//  writedata      in   64      write data
//  write          in   1       Avalon write strobe
//  read           in   1       Avalon read strobe
//  byteenable     in   8       per-byte write enable
//  readdata       out  64      read data; registered, valid when readdatavalid=1
//  readdatavalid  out  1       one-cycle pulse, one cycle after an accepted read
//  waitrequest    out  1       tied 0; every access is accepted in the cycle it is presented
//  irq            out  1       level; = STATUS.done & CTRL.irq_en
// BEHAVIOUR
//  Address map (E = MAT_N*MAT_N):
//   - A: 0..E-1, read/write.
//   - B: E..2E-1, read/write.
//   - C: 2E..3E-1, read-only; writes are dropped.
//   - CTRL: 3E.
//   - STATUS: 3E+1.
//   - Any other address: reads return 0, writes are dropped.
//  CTRL: bit0 start (write-1 pulse, self-clearing, reads 0); bit1 irq_en (read/write).
//  STATUS: bit0 busy (RO); bit1 done (sticky, W1C); bit2 err_timeout (sticky, W1C); bit3 err_wr (sticky, W1C).
//  Byte writes: byte k of the target word updates only when byteenable[k]=1. Any mix is legal, including 0x00.
//  Read latency is exactly 1: readdata and readdatavalid are registered from address at the read cycle.
//  Core drive: core rst = ~reset_n; core mat_a/mat_b are flattened with element j at bits [64j +: 64].
//  FSM:
//   - IDLE: write of CTRL.start=1 -> LOAD. In the same cycle clear done, err_timeout and err_wr.
//   - LOAD: 1 cycle; pack the A/B banks into the core input registers -> RUN.
//   - RUN: hold start=1 and valid=1; count cycles.
//       * core done=1 -> CAPT.
//       * count reaches TIMEOUT_CYC with no done -> set err_timeout, drop start/valid -> IDLE; C is unchanged.
//       * done and timeout in the same cycle: done wins.
//   - CAPT: 1 cycle; C[j] <= mat_out[64j +: 64]; set done; drop start/valid -> IDLE.
//  busy = 1 in LOAD, RUN and CAPT.
//  Busy rules:
//   - A start write while busy is ignored.
//   - A write to A or B while busy is dropped and sets err_wr.
//   - C reads while busy return the previous result.
//   - CSR and A/B reads are always served.
//  A W1C write in the same cycle as that flag's hardware set: the set wins.
//  Reset: FSM IDLE; CTRL, STATUS, readdata and readdatavalid = 0; irq = 0; core inputs = 0.
//   - Bank contents are undefined after reset; the bench initialises them first.
//   - Reset asserted mid-RUN aborts the run; C keeps its old contents.
// TESTING
//  1. Load A=I, B=k*(1+2i) for k=0..8 (MAT_N=3); start; poll until done=1 -> C equals B, busy=0, err bits=0.
//  2. Load A[0]=0x00000002_00000001 via byteenable 0x0F then 0xF0, B=I -> C[0]=0x00000002_00000001;
//     a byteenable=0x01 write changes only byte 0.
//  3. Set irq_en=1, start -> irq rises the cycle after CAPT. Write STATUS=0x2 -> irq=0 next cycle.
//  4. Write A during RUN -> A unchanged, err_wr=1. A second start during RUN is ignored; the core runs once.
//  5. TIMEOUT_CYC=16 with a core stub that never asserts done -> err_timeout=1 after 16 RUN cycles,
//     busy=0, C unchanged.
//  6. Pull reset_n low mid-RUN for 1 cycle -> STATUS=0 and irq=0. A restart then completes with correct C.

Source files
------------

// File: rtl/avalon_mat_mult_csr.sv
// Avalon-MM CSR front-end for the complex matrix multiplier, plus the multiplier core itself.
// Each complex element is one 64-bit word {imag[63:32], real[31:0]}. Software loads A/B, writes CTRL.start,
// then polls STATUS or waits for irq, and reads C.
// Ports (avalon_mat_mult_csr):
//   clk, reset_n (sync, active-low)
//   address/writedata/write/read/byteenable  Avalon-MM slave request, 64-bit words
//   readdata/readdatavalid                   registered read response, latency 1
//   waitrequest                              constant 0
//   irq                                      level, STATUS.done & CTRL.irq_en
// Ports (mat_mult_complex):
//   clk, rst (sync, active-high), start/valid, mat_a/mat_b flattened inputs, mat_out result, done

module mat_mult_complex #(
    parameter int unsigned MAT_N = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        valid,
    input  logic [64*MAT_N*MAT_N-1:0]   mat_a,
    input  logic [64*MAT_N*MAT_N-1:0]   mat_b,
    output logic [64*MAT_N*MAT_N-1:0]   mat_out,
    output logic                        done
);
    localparam int unsigned IW = (MAT_N > 1) ? $clog2(MAT_N) : 1;

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIN} mstate_t;
    mstate_t state, state_nxt;

    logic [IW-1:0] row, col, k;
    logic [31:0]   acc_re, acc_im, sum_re, sum_im;
    logic [31:0]   ar, ai, br, bi;
    logic [63:0]   a_el, b_el;
    int unsigned   a_idx, b_idx, o_idx;
    logic          go, last_k, last_col, last_el;

    // One complex MAC per cycle, walking k fastest, then col, then row
    assign go       = start && valid;
    assign a_idx    = 32'(row) * MAT_N + 32'(k);
    assign b_idx    = 32'(k) * MAT_N + 32'(col);
    assign o_idx    = 32'(row) * MAT_N + 32'(col);
    assign a_el     = mat_a[64*a_idx +: 64];
    assign b_el     = mat_b[64*b_idx +: 64];
    assign ar       = a_el[31:0];
    assign ai       = a_el[63:32];
    assign br       = b_el[31:0];
    assign bi       = b_el[63:32];
    assign sum_re   = acc_re + ar * br - ai * bi;
    assign sum_im   = acc_im + ar * bi + ai * br;
    assign last_k   = (k == IW'(MAT_N - 1));
    assign last_col = (col == IW'(MAT_N - 1));
    assign last_el  = last_k && last_col && (row == IW'(MAT_N - 1));

    // Next state: dropping start aborts a run; done is held until start falls
    always_comb begin
        state_nxt = state;
        case (state)
            M_IDLE:  if (go) state_nxt = M_RUN;
            M_RUN:   if (!go) state_nxt = M_IDLE;
                     else if (last_el) state_nxt = M_FIN;
            M_FIN:   if (!start) state_nxt = M_IDLE;
            default: state_nxt = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= M_IDLE;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            acc_re  <= '0;
            acc_im  <= '0;
            mat_out <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == M_FIN);
            if (state != M_RUN) begin
                row    <= '0;
                col    <= '0;
                k      <= '0;
                acc_re <= '0;
                acc_im <= '0;
            end else if (go) begin
                if (last_k) begin
                    mat_out[64*o_idx +: 64] <= {sum_im, sum_re};
                    acc_re <= '0;
                    acc_im <= '0;
                    k      <= '0;
                    if (last_col) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end else begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    k      <= k + 1'b1;
                end
            end
        end
    end
endmodule

module avalon_mat_mult_csr #(
    parameter int unsigned MAT_N       = 3,
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       writedata,
    input  logic              write,
    input  logic              read,
    input  logic [7:0]        byteenable,
    output logic [63:0]       readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    output logic              irq
);
    localparam int unsigned E     = MAT_N * MAT_N;
    localparam int unsigned IDX_W = (E > 1) ? $clog2(E) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic              TO_EN     = (TIMEOUT_CYC != 0);
    localparam logic [ADDR_W-1:0] B_BASE    = ADDR_W'(E);
    localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(2 * E);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(3 * E);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(3 * E + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT} state_t;
    state_t state, state_nxt;

    logic [63:0]      bank_a [E];
    logic [63:0]      bank_b [E];
    logic [63:0]      bank_c [E];
    logic [64*E-1:0]  core_a, core_b, core_out;
    logic             core_go, core_done, core_rst;
    logic [CNT_W-1:0] run_cnt;
    logic             irq_en, st_done, st_err_to, st_err_wr;
    logic             irq_en_nxt, done_nxt, err_to_nxt, err_wr_nxt;
    logic             in_a, in_b, in_c, is_ctrl, is_stat, busy;
    logic             start_wr, start_hit, load_en, capt_en, to_hit;
    logic [IDX_W-1:0] idx_a, idx_b, idx_c;
    logic [63:0]      rd_mux;

    function automatic logic [63:0] merge_be(input logic [63:0] old_w, input logic [63:0] new_w,
                                             input logic [7:0] be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    assign waitrequest = 1'b0;
    assign core_rst    = ~reset_n;

    // Address decode
    assign in_a    = (address < B_BASE);
    assign in_b    = (address >= B_BASE) && (address < C_BASE);
    assign in_c    = (address >= C_BASE) && (address < CTRL_ADDR);
    assign is_ctrl = (address == CTRL_ADDR);
    assign is_stat = (address == STAT_ADDR);
    assign idx_a   = IDX_W'(address);
    assign idx_b   = IDX_W'(address - B_BASE);
    assign idx_c   = IDX_W'(address - C_BASE);
    assign busy    = (state != S_IDLE);
    assign start_wr = write && is_ctrl && byteenable[0] && writedata[0];

    // Control FSM next state and one-cycle strobes
    always_comb begin
        state_nxt = state;
        start_hit = 1'b0;
        load_en   = 1'b0;
        capt_en   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            S_IDLE: if (start_wr) begin
                state_nxt = S_LOAD;
                start_hit = 1'b1;
            end
            S_LOAD: begin
                load_en   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: if (core_done) begin
                state_nxt = S_CAPT;
            end else if (TO_EN && (run_cnt == TO_LAST)) begin
                to_hit    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_CAPT: begin
                capt_en   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CSR next values; hardware sets are applied last so they beat a coincident W1C
    always_comb begin
        irq_en_nxt = irq_en;
        done_nxt   = st_done;
        err_to_nxt = st_err_to;
        err_wr_nxt = st_err_wr;
        if (write && is_ctrl && byteenable[0]) irq_en_nxt = writedata[1];
        if (write && is_stat && byteenable[0]) begin
            if (writedata[1]) done_nxt   = 1'b0;
            if (writedata[2]) err_to_nxt = 1'b0;
            if (writedata[3]) err_wr_nxt = 1'b0;
        end
        if (start_hit) begin
            done_nxt   = 1'b0;
            err_to_nxt = 1'b0;
            err_wr_nxt = 1'b0;
        end
        if (capt_en) done_nxt = 1'b1;
        if (to_hit) err_to_nxt = 1'b1;
        if (busy && write && (in_a || in_b)) err_wr_nxt = 1'b1;
    end

    // Read data mux
    always_comb begin
        rd_mux = '0;
        if (in_a)         rd_mux = bank_a[idx_a];
        else if (in_b)    rd_mux = bank_b[idx_b];
        else if (in_c)    rd_mux = bank_c[idx_c];
        else if (is_ctrl) rd_mux = {62'd0, irq_en, 1'b0};
        else if (is_stat) rd_mux = {60'd0, st_err_wr, st_err_to, st_done, busy};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en        <= 1'b0;
            st_done       <= 1'b0;
            st_err_to     <= 1'b0;
            st_err_wr     <= 1'b0;
            irq           <= 1'b0;
            run_cnt       <= '0;
            core_go       <= 1'b0;
            core_a        <= '0;
            core_b        <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            irq_en        <= irq_en_nxt;
            st_done       <= done_nxt;
            st_err_to     <= err_to_nxt;
            st_err_wr     <= err_wr_nxt;
            irq           <= done_nxt & irq_en_nxt;
            run_cnt       <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
            readdatavalid <= read;
            if (read) readdata <= rd_mux;
            if (load_en) begin
                core_go <= 1'b1;
                for (int j = 0; j < E; j++) begin
                    core_a[64*j +: 64] <= bank_a[j];
                    core_b[64*j +: 64] <= bank_b[j];
                end
            end else if (capt_en || to_hit) begin
                core_go <= 1'b0;
            end
        end
    end

    // Banks are not reset; A/B writes are dropped while busy, C is written only on capture
    always_ff @(posedge clk) begin
        if (write && in_a && !busy) bank_a[idx_a] <= merge_be(bank_a[idx_a], writedata, byteenable);
        if (write && in_b && !busy) bank_b[idx_b] <= merge_be(bank_b[idx_b], writedata, byteenable);
        if (capt_en) begin
            for (int j = 0; j < E; j++) bank_c[j] <= core_out[64*j +: 64];
        end
    end

    mat_mult_complex #(.MAT_N(MAT_N)) u_core (
        .clk     (clk),
        .rst     (core_rst),
        .start   (core_go),
        .valid   (core_go),
        .mat_a   (core_a),
        .mat_b   (core_b),
        .mat_out (core_out),
        .done    (core_done)
    );
endmodule

// File: tb/tb_avalon_mat_mult_csr.sv
// Directed bench for avalon_mat_mult_csr: a default instance and a second one with a 16-cycle timeout,
// which the multiplier core (several dozen cycles per 3x3 product) can never beat.
module tb_avalon_mat_mult_csr;
    localparam int unsigned A0 = 0, B0 = 9, C0 = 18, CTRL = 27, STAT = 28;

    logic        clk, reset_n;
    logic [22:0] address, t_address;
    logic [63:0] writedata, t_writedata, readdata, t_readdata;
    logic        write, read, t_write, t_read;
    logic [7:0]  byteenable, t_byteenable;
    logic        readdatavalid, t_readdatavalid, waitrequest, t_waitrequest, irq, t_irq;

    int vectors, miscompares;

    avalon_mat_mult_csr dut (
        .clk(clk), .reset_n(reset_n), .address(address), .writedata(writedata), .write(write),
        .read(read), .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .irq(irq)
    );

    avalon_mat_mult_csr #(.TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .reset_n(reset_n), .address(t_address), .writedata(t_writedata), .write(t_write),
        .read(t_read), .byteenable(t_byteenable), .readdata(t_readdata), .readdatavalid(t_readdatavalid),
        .waitrequest(t_waitrequest), .irq(t_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] bk(input int unsigned k);
        return {32'(2 * k), 32'(k)};
    endfunction

    task automatic bus_wr(input bit s, input int unsigned a, input logic [63:0] d, input logic [7:0] be);
        @(negedge clk);
        if (s) begin
            t_address = 23'(a); t_writedata = d; t_byteenable = be; t_write = 1'b1;
        end else begin
            address = 23'(a); writedata = d; byteenable = be; write = 1'b1;
        end
        @(posedge clk); #1;
        write = 1'b0; t_write = 1'b0;
    endtask

    task automatic bus_rd(input bit s, input int unsigned a, output logic [63:0] d, output logic v);
        @(negedge clk);
        if (s) begin t_address = 23'(a); t_read = 1'b1; end
        else   begin address = 23'(a); read = 1'b1; end
        @(posedge clk); #1;
        d = s ? t_readdata : readdata;
        v = s ? t_readdatavalid : readdatavalid;
        read = 1'b0; t_read = 1'b0;
    endtask

    task automatic wait_done(input bit s, output bit ok, output logic [63:0] st);
        logic v;
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < 200; i++) begin
            bus_rd(s, STAT, st, v);
            if (st[1]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic load_a_identity(input bit s);
        for (int j = 0; j < 9; j++) bus_wr(s, A0 + j, (j % 4 == 0) ? 64'd1 : 64'd0, 8'hFF);
    endtask

    task automatic test_reset;
        logic [63:0] d; logic v;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (readdata !== 64'd0) begin miscompares++; $display("FAIL reset_readdata got %h want 0", readdata); end
        vectors++; if (readdatavalid !== 1'b0) begin miscompares++; $display("FAIL reset_rdv got %b want 0", readdatavalid); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
        vectors++; if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL waitrequest got %b want 0", waitrequest); end
        @(negedge clk); reset_n = 1'b1;
        bus_rd(0, STAT, d, v);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL reset_status got %h want 0", d); end
        vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL rdv_pulse got %b want 1", v); end
        @(posedge clk); #1;
        vectors++; if (readdatavalid !== 1'b0) begin miscompares++; $display("FAIL rdv_one_cycle got %b want 0", readdatavalid); end
        bus_rd(0, CTRL, d, v);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL reset_ctrl got %h want 0", d); end
        bus_rd(1, STAT, d, v);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL reset_status_to got %h want 0", d); end
    endtask

    task automatic test_identity;
        logic [63:0] d, st; logic v; bit ok;
        load_a_identity(0);
        for (int k = 0; k < 9; k++) bus_wr(0, B0 + k, bk(k), 8'hFF);
        bus_wr(0, CTRL, 64'h1, 8'hFF);
        wait_done(0, ok, st);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ident_done timeout status %h want done", st); end
        vectors++; if (st !== 64'h2) begin miscompares++; $display("FAIL ident_status got %h want 2", st); end
        for (int k = 0; k < 9; k++) begin
            bus_rd(0, C0 + k, d, v);
            vectors++; if (d !== bk(k)) begin miscompares++; $display("FAIL ident_c%0d got %h want %h", k, d, bk(k)); end
        end
        bus_wr(0, C0 + 3, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
        bus_rd(0, C0 + 3, d, v);
        vectors++; if (d !== bk(3)) begin miscompares++; $display("FAIL c_readonly got %h want %h", d, bk(3)); end
        bus_wr(0, 200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        bus_rd(0, 200, d, v);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL unmapped_200 got %h want 0", d); end
        bus_rd(0, STAT + 1, d, v);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL unmapped_29 got %h want 0", d); end
    endtask

    task automatic test_byteenable;
        logic [63:0] d, st; logic v; bit ok;
        for (int j = 1; j < 9; j++) bus_wr(0, A0 + j, 64'd0, 8'hFF);
        for (int j = 0; j < 9; j++) bus_wr(0, B0 + j, (j % 4 == 0) ? 64'd1 : 64'd0, 8'hFF);
        bus_wr(0, A0, 64'h1111_1111_2222_2222, 8'hFF);
        bus_wr(0, A0, 64'hDEAD_BEEF_0000_0001, 8'h0F);
        bus_rd(0, A0, d, v);
        vectors++; if (d !== 64'h1111_1111_0000_0001) begin miscompares++; $display("FAIL be_0f got %h want 1111111100000001", d); end
        bus_wr(0, A0, 64'h0000_0002_CAFE_F00D, 8'hF0);
        bus_rd(0, A0, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_0001) begin miscompares++; $display("FAIL be_f0 got %h want 0000000200000001", d); end
        bus_wr(0, CTRL, 64'h1, 8'hFF);
        wait_done(0, ok, st);
        vectors++; if (!ok) begin miscompares++; $display("FAIL be_done timeout status %h want done", st); end
        bus_rd(0, C0, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_0001) begin miscompares++; $display("FAIL be_c0 got %h want 0000000200000001", d); end
        bus_rd(0, C0 + 4, d, v);
        vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL be_c4 got %h want 0", d); end
        bus_wr(0, A0, 64'hFFFF_FFFF_FFFF_FFAA, 8'h01);
        bus_rd(0, A0, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_00AA) begin miscompares++; $display("FAIL be_01 got %h want 00000002000000aa", d); end
        bus_wr(0, A0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        bus_rd(0, A0, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_00AA) begin miscompares++; $display("FAIL be_00 got %h want 00000002000000aa", d); end
    endtask

    task automatic test_irq;
        logic [63:0] d; logic v; bit seen;
        bus_wr(0, STAT, 64'hE, 8'hFF);
        bus_wr(0, CTRL, 64'h2, 8'hFF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle got %b want 0", irq); end
        bus_rd(0, CTRL, d, v);
        vectors++; if (d !== 64'h2) begin miscompares++; $display("FAIL ctrl_irq_en got %h want 2", d); end
        bus_wr(0, CTRL, 64'h3, 8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin seen = 1'b1; break; end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL irq_rise got 0 want 1 within 200 cycles"); end
        bus_rd(0, STAT, d, v);
        vectors++; if (d !== 64'h2) begin miscompares++; $display("FAIL irq_status got %h want 2", d); end
        bus_rd(0, CTRL, d, v);
        vectors++; if (d !== 64'h2) begin miscompares++; $display("FAIL ctrl_start_reads0 got %h want 2", d); end
        bus_rd(0, C0, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_00AA) begin miscompares++; $display("FAIL irq_c0 got %h want 00000002000000aa", d); end
        bus_wr(0, STAT, 64'h2, 8'hFF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_w1c got %b want 0", irq); end
    endtask

    task automatic test_busy;
        logic [63:0] d, st; logic v; bit ok;
        load_a_identity(0);
        for (int k = 0; k < 9; k++) bus_wr(0, B0 + k, bk(k), 8'hFF);
        bus_wr(0, CTRL, 64'h3, 8'hFF);
        bus_wr(0, A0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        bus_wr(0, CTRL, 64'h3, 8'hFF);
        bus_rd(0, STAT, d, v);
        vectors++; if (d !== 64'h9) begin miscompares++; $display("FAIL busy_status got %h want 9", d); end
        bus_rd(0, C0, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_00AA) begin miscompares++; $display("FAIL busy_c_prev got %h want 00000002000000aa", d); end
        bus_rd(0, A0 + 4, d, v);
        vectors++; if (d !== 64'd1) begin miscompares++; $display("FAIL busy_a_read got %h want 1", d); end
        wait_done(0, ok, st);
        vectors++; if (st !== 64'hA) begin miscompares++; $display("FAIL busy_final got %h want a", st); end
        bus_rd(0, A0, d, v);
        vectors++; if (d !== 64'd1) begin miscompares++; $display("FAIL busy_a_kept got %h want 1", d); end
        bus_rd(0, C0 + 1, d, v);
        vectors++; if (d !== bk(1)) begin miscompares++; $display("FAIL busy_c1 got %h want %h", d, bk(1)); end
        bus_rd(0, C0 + 8, d, v);
        vectors++; if (d !== bk(8)) begin miscompares++; $display("FAIL busy_c8 got %h want %h", d, bk(8)); end
        repeat (40) @(posedge clk);
        bus_rd(0, STAT, d, v);
        vectors++; if (d !== 64'hA) begin miscompares++; $display("FAIL single_run got %h want a", d); end
    endtask

    task automatic test_timeout;
        logic [63:0] d; logic v;
        load_a_identity(1);
        for (int k = 0; k < 9; k++) bus_wr(1, B0 + k, bk(k), 8'hFF);
        bus_wr(1, CTRL, 64'h1, 8'hFF);
        repeat (16) @(posedge clk);
        bus_rd(1, STAT, d, v);
        vectors++; if (d !== 64'h1) begin miscompares++; $display("FAIL to_still_busy got %h want 1", d); end
        bus_rd(1, STAT, d, v);
        vectors++; if (d !== 64'h4) begin miscompares++; $display("FAIL to_flag got %h want 4", d); end
        vectors++; if (t_irq !== 1'b0) begin miscompares++; $display("FAIL to_irq got %b want 0", t_irq); end
        bus_wr(1, STAT, 64'h4, 8'hFF);
        bus_rd(1, STAT, d, v);
        vectors++; if (d !== 64'h0) begin miscompares++; $display("FAIL to_w1c got %h want 0", d); end
    endtask

    task automatic test_reset_mid_run;
        logic [63:0] d, st; logic v; bit ok;
        for (int k = 0; k < 9; k++) bus_wr(0, B0 + k, {32'(k), 32'(3 * k)}, 8'hFF);
        bus_wr(0, CTRL, 64'h1, 8'hFF);
        repeat (5) @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got %b want 0", irq); end
        bus_rd(0, STAT, d, v);
        vectors++; if (d !== 64'h0) begin miscompares++; $display("FAIL rst_status got %h want 0", d); end
        bus_rd(0, CTRL, d, v);
        vectors++; if (d !== 64'h0) begin miscompares++; $display("FAIL rst_ctrl got %h want 0", d); end
        bus_rd(0, C0 + 2, d, v);
        vectors++; if (d !== bk(2)) begin miscompares++; $display("FAIL rst_c_kept got %h want %h", d, bk(2)); end
        bus_wr(0, CTRL, 64'h1, 8'hFF);
        wait_done(0, ok, st);
        vectors++; if (st !== 64'h2) begin miscompares++; $display("FAIL restart_status got %h want 2", st); end
        bus_rd(0, C0 + 2, d, v);
        vectors++; if (d !== 64'h0000_0002_0000_0006) begin miscompares++; $display("FAIL restart_c2 got %h want 0000000200000006", d); end
        bus_rd(0, C0 + 7, d, v);
        vectors++; if (d !== 64'h0000_0007_0000_0015) begin miscompares++; $display("FAIL restart_c7 got %h want 0000000700000015", d); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset_n = 1'b0;
        address = '0; writedata = '0; write = 1'b0; read = 1'b0; byteenable = '0;
        t_address = '0; t_writedata = '0; t_write = 1'b0; t_read = 1'b0; t_byteenable = '0;
        test_reset();
        test_identity();
        test_byteenable();
        test_irq();
        test_busy();
        test_timeout();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
